// File: rtl/fighter_motion_ctrl_if.sv
// ---------------------------------------------------------------------------
// fighter_motion_ctrl_if
//   Bundles the game-side inputs and renderer-side outputs of one fighter's
//   motion controller.
//
//   master modport : drives tick, buttons and opponent_x; reads the outputs
//   slave  modport : the controller itself
//
//   Signals
//     tick            one-clk game-tick enable pulse (8 Hz)
//     btn_*           debounced button levels (left/right/up/down/attack)
//     opponent_x[6:0] other fighter's x
//     x, y[6:0]       sprite centre position
//     in_air          1 while jumping
//     move_state[1:0] 00 idle, 01 forward, 10 backward
//     character_state 000 normal, 001 punch, 010 special, 011 super
//     mirror          1 = facing left
//     dbg_atk_state   attack FSM state register, for observation only
//
//   Handshake semantics: there is no valid/ready pair on this interface.
//   tick is a single-cycle qualifier, buttons are levels sampled every clk,
//   and all outputs are registered levels with no backpressure.
// ---------------------------------------------------------------------------
interface fighter_motion_ctrl_if;
  logic       tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       btn_attack;
  logic [6:0] opponent_x;
  logic [6:0] x;
  logic [6:0] y;
  logic       in_air;
  logic [1:0] move_state;
  logic [2:0] character_state;
  logic       mirror;
  logic [1:0] dbg_atk_state;

  modport master (
    output tick, btn_left, btn_right, btn_up, btn_down, btn_attack, opponent_x,
    input  x, y, in_air, move_state, character_state, mirror, dbg_atk_state
  );

  modport slave (
    input  tick, btn_left, btn_right, btn_up, btn_down, btn_attack, opponent_x,
    output x, y, in_air, move_state, character_state, mirror, dbg_atk_state
  );
endinterface

// File: rtl/fighter_motion_ctrl.sv
// ---------------------------------------------------------------------------
// fighter_motion_ctrl
//   Per-fighter motion/action controller feeding the sprite renderer.
//   Handles horizontal walking, jump physics, facing, punch/special timing
//   and combo-sequence detection. All state advances on tick cycles only;
//   button edges are captured every clk.
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    fighter_motion_ctrl_if.slave (inputs: tick, btn_*, opponent_x;
//            outputs: x, y, in_air, move_state, character_state, mirror,
//            dbg_atk_state)
//
//   Optional feature: define SUPER_COMBO_EN to widen the direction history
//   to 8 entries and enable the U,D,U,D,L,R,L,R super move (state 011).
// ---------------------------------------------------------------------------
module fighter_motion_ctrl #(
  parameter int X_MIN        = 8,
  parameter int X_MAX        = 88,
  parameter int X_START      = 24,
  parameter int GROUND_Y     = 32,
  parameter int STEP         = 1,
  parameter int JUMP_V0      = 6,
  parameter int PUNCH_TICKS  = 2,
  parameter int SP_TICKS     = 4,
  parameter int COMBO_WINDOW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fighter_motion_ctrl_if.slave  bus
);

`ifdef SUPER_COMBO_EN
  localparam int HIST_N = 8;
`else
  localparam int HIST_N = 4;
`endif

  localparam int                WIN_W    = $clog2(COMBO_WINDOW + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(COMBO_WINDOW - 1);
  localparam logic [WIN_W-1:0]  WIN_FULL = WIN_W'(COMBO_WINDOW);
  localparam logic [6:0]        X_MIN7   = 7'(X_MIN);
  localparam logic [6:0]        X_MAX7   = 7'(X_MAX);
  localparam logic [6:0]        X_START7 = 7'(X_START);
  localparam logic [6:0]        GROUND7  = 7'(GROUND_Y);
  localparam logic [6:0]        STEP7    = 7'(STEP);
  localparam logic signed [8:0] GROUND9  = 9'(GROUND_Y);
  localparam logic signed [4:0] V0       = 5'(JUMP_V0);
  localparam logic [3:0]        PUNCH_T  = 4'(PUNCH_TICKS);
  localparam logic [3:0]        SP_T     = 4'(SP_TICKS);

  // History entry codes; zero marks an empty slot.
  localparam logic [2:0] C_L = 3'd1;
  localparam logic [2:0] C_R = 3'd2;
  localparam logic [2:0] C_U = 3'd3;
  localparam logic [2:0] C_D = 3'd4;

  localparam logic [1:0] MV_IDLE = 2'b00;
  localparam logic [1:0] MV_FWD  = 2'b01;
  localparam logic [1:0] MV_BACK = 2'b10;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'b00,
    ST_PUNCH   = 2'b01,
    ST_SPECIAL = 2'b10,
    ST_SUPER   = 2'b11
  } atk_state_e;

  atk_state_e             state_q, state_d;
  logic [4:0]             btn_now, btn_q, edge_v;
  logic                   pend_up_q, pend_up_d, pend_atk_q, pend_atk_d;
  logic                   pend_up_now, pend_atk_now, dir_edge;
  logic [HIST_N-1:0][2:0] hist_q, hist_d, hist_sh;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [3:0]             timer_q, timer_d;
  logic [6:0]             x_q, x_d, y_q, y_d;
  logic                   in_air_q, in_air_d, mirror_q, mirror_d, launch;
  logic signed [4:0]      vy_q, vy_d, vy_eff;
  logic signed [8:0]      y_sum;
  logic [1:0]             move_q, move_d;
  logic                   combo_sp, combo_super;

  function automatic logic [2:0] dir_code(input int idx);
    case (idx)
      0:       return C_L;
      1:       return C_R;
      2:       return C_U;
      default: return C_D;
    endcase
  endfunction

  // Bit order: [0] left, [1] right, [2] up, [3] down, [4] attack.
  assign btn_now = {bus.btn_attack, bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};
  assign edge_v  = btn_now & ~btn_q;

  always_comb begin
    // Direction edges enter the history in the same clk they are seen, so a
    // combo completed on a tick cycle is already visible to that tick.
    hist_sh  = hist_q;
    dir_edge = |edge_v[3:0];
    for (int i = 0; i < 4; i++) begin
      if (edge_v[i]) hist_sh = {hist_sh[HIST_N-2:0], dir_code(i)};
    end

    pend_up_now  = pend_up_q  | edge_v[2];
    pend_atk_now = pend_atk_q | edge_v[4];

    // Take-off tick also applies the first airborne step.
    launch = pend_up_now && !in_air_q;
    vy_eff = launch ? V0 : vy_q;
    y_sum  = $signed({2'b00, y_q}) - $signed({{4{vy_eff[4]}}, vy_eff});

    hist_d      = hist_sh;
    win_d       = dir_edge ? '0 : win_q;
    pend_up_d   = pend_up_now;
    pend_atk_d  = pend_atk_now;
    state_d     = state_q;
    timer_d     = timer_q;
    x_d         = x_q;
    y_d         = y_q;
    in_air_d    = in_air_q;
    vy_d        = vy_q;
    mirror_d    = mirror_q;
    move_d      = move_q;
    combo_sp    = 1'b0;
    combo_super = 1'b0;

    if (bus.tick) begin
      pend_up_d  = 1'b0;
      pend_atk_d = 1'b0;

      // Window counter saturates; history drops once the window has elapsed.
      if (!dir_edge) begin
        if (win_q >= WIN_LAST) hist_d = '0;
        if (win_q < WIN_FULL) win_d = win_q + WIN_W'(1);
      end

      combo_sp = (hist_d[2] == C_L) && (hist_d[1] == C_D) && (hist_d[0] == C_R);
`ifdef SUPER_COMBO_EN
      combo_super = (hist_d == {C_U, C_D, C_U, C_D, C_L, C_R, C_L, C_R});
`else
      combo_super = 1'b0;
`endif

      if (bus.opponent_x < x_q)      mirror_d = 1'b1;
      else if (bus.opponent_x > x_q) mirror_d = 1'b0;

      case (state_q)
        ST_NORMAL: begin
          if (pend_atk_now) begin
            hist_d = '0;
            if (combo_super) begin
              state_d = ST_SUPER;
              timer_d = SP_T;
            end else if (combo_sp) begin
              state_d = ST_SPECIAL;
              timer_d = SP_T;
            end else begin
              state_d = ST_PUNCH;
              timer_d = PUNCH_T;
            end
          end
        end
        default: begin
          // Attack edges in this state are simply dropped with the pending flag.
          if (timer_q <= 4'd1) begin
            state_d = ST_NORMAL;
            timer_d = 4'd0;
          end else begin
            timer_d = timer_q - 4'd1;
          end
        end
      endcase

      // Movement is gated on the post-tick attack state so the outputs never
      // show an attack together with a non-idle move.
      if ((state_d == ST_NORMAL) && (bus.btn_right ^ bus.btn_left)) begin
        if (bus.btn_right) begin
          x_d    = (x_q >= X_MAX7 - STEP7) ? X_MAX7 : x_q + STEP7;
          move_d = mirror_d ? MV_BACK : MV_FWD;
        end else begin
          x_d    = (x_q <= X_MIN7 + STEP7) ? X_MIN7 : x_q - STEP7;
          move_d = mirror_d ? MV_FWD : MV_BACK;
        end
      end else begin
        move_d = MV_IDLE;
      end

      if (launch || in_air_q) begin
        if (y_sum >= GROUND9) begin
          y_d      = GROUND7;
          in_air_d = 1'b0;
          vy_d     = '0;
        end else begin
          y_d      = y_sum[6:0];
          in_air_d = 1'b1;
          vy_d     = vy_eff - 5'sd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_NORMAL;
      btn_q      <= '0;
      pend_up_q  <= 1'b0;
      pend_atk_q <= 1'b0;
      hist_q     <= '0;
      win_q      <= '0;
      timer_q    <= '0;
      x_q        <= X_START7;
      y_q        <= GROUND7;
      in_air_q   <= 1'b0;
      vy_q       <= '0;
      mirror_q   <= 1'b0;
      move_q     <= MV_IDLE;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_now;
      pend_up_q  <= pend_up_d;
      pend_atk_q <= pend_atk_d;
      hist_q     <= hist_d;
      win_q      <= win_d;
      timer_q    <= timer_d;
      x_q        <= x_d;
      y_q        <= y_d;
      in_air_q   <= in_air_d;
      vy_q       <= vy_d;
      mirror_q   <= mirror_d;
      move_q     <= move_d;
    end
  end

  assign bus.x               = x_q;
  assign bus.y               = y_q;
  assign bus.in_air          = in_air_q;
  assign bus.move_state      = move_q;
  assign bus.character_state = {1'b0, state_q};
  assign bus.mirror          = mirror_q;
  assign bus.dbg_atk_state   = state_q;

endmodule

// File: tb/tb_fighter_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fighter_motion_ctrl
//   Directed bench for fighter_motion_ctrl. A behavioural model tracks the
//   expected outputs from the game rules (closed-form jump height, history as
//   a queue of direction letters, attack as remaining-tick count); a negedge
//   process compares every output each cycle, and literal expectations from
//   hand calculation pin the model.
// ---------------------------------------------------------------------------
module tb_fighter_motion_ctrl;
  localparam int X_MIN = 8, X_MAX = 88, X_START = 24, GROUND_Y = 32, STEP = 1;
  localparam int JUMP_V0 = 6, PUNCH_TICKS = 2, SP_TICKS = 4, COMBO_WINDOW = 8;
`ifdef SUPER_COMBO_EN
  localparam bit SUPER = 1'b1;
`else
  localparam bit SUPER = 1'b0;
`endif
  localparam int B_L = 0, B_R = 1, B_U = 2, B_D = 3, B_A = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   cmp_en = 1'b0;

  fighter_motion_ctrl_if bus();

  fighter_motion_ctrl #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .X_START(X_START), .GROUND_Y(GROUND_Y),
    .STEP(STEP), .JUMP_V0(JUMP_V0), .PUNCH_TICKS(PUNCH_TICKS),
    .SP_TICKS(SP_TICKS), .COMBO_WINDOW(COMBO_WINDOW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_x, m_y, m_k, m_move, m_char, m_left, m_since;
  bit       m_air, m_mirror, m_pu, m_pa;
  bit [4:0] m_prev;
  byte      m_hist[$];

  task automatic model_reset();
    m_x = X_START; m_y = GROUND_Y; m_k = 0; m_move = 0; m_char = 0; m_left = 0;
    m_since = 0; m_air = 0; m_mirror = 0; m_pu = 0; m_pa = 0; m_prev = '0;
    m_hist.delete();
  endtask

  function automatic bit tail_is(input string pat);
    int n = pat.len();
    if (m_hist.size() < n) return 1'b0;
    for (int i = 0; i < n; i++)
      if (m_hist[m_hist.size() - n + i] != pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit [4:0] b;
    bit       dir_seen;
    string    names;
    int       h;
    names = "LRUD";
    b = {bus.btn_attack, bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};
    dir_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (b[i] && !m_prev[i]) begin
        m_hist.push_back(names[i]);
        dir_seen = 1'b1;
        m_since = 0;
      end
    end
    while (m_hist.size() > 8) void'(m_hist.pop_front());
    if (b[B_U] && !m_prev[B_U]) m_pu = 1'b1;
    if (b[B_A] && !m_prev[B_A]) m_pa = 1'b1;
    m_prev = b;
    if (!bus.tick) return;

    if (!dir_seen) begin
      m_since++;
      if (m_since >= COMBO_WINDOW) m_hist.delete();
    end

    if (bus.opponent_x < m_x) m_mirror = 1'b1;
    else if (bus.opponent_x > m_x) m_mirror = 1'b0;

    if (m_char != 0) begin
      m_left--;
      if (m_left == 0) m_char = 0;
    end else if (m_pa) begin
      if (SUPER && tail_is("UDUDLRLR")) begin m_char = 3; m_left = SP_TICKS; end
      else if (tail_is("LDR"))          begin m_char = 2; m_left = SP_TICKS; end
      else                              begin m_char = 1; m_left = PUNCH_TICKS; end
      m_hist.delete();
    end
    m_pa = 1'b0;

    if (m_char == 0 && (bus.btn_right != bus.btn_left)) begin
      if (bus.btn_right) begin
        m_x    = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
        m_move = m_mirror ? 2 : 1;
      end else begin
        m_x    = (m_x - STEP < X_MIN) ? X_MIN : m_x - STEP;
        m_move = m_mirror ? 1 : 2;
      end
    end else begin
      m_move = 0;
    end

    if (m_pu && !m_air) begin m_air = 1'b1; m_k = 0; end
    m_pu = 1'b0;
    if (m_air) begin
      m_k++;
      h = m_k * JUMP_V0 - (m_k * (m_k - 1)) / 2;
      if (h <= 0) begin m_air = 1'b0; m_y = GROUND_Y; end
      else m_y = GROUND_Y - h;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_x",      bus.x,               m_x);
      chk("model_y",      bus.y,               m_y);
      chk("model_in_air", bus.in_air,          m_air);
      chk("model_move",   bus.move_state,      m_move);
      chk("model_char",   bus.character_state, m_char);
      chk("model_mirror", bus.mirror,          m_mirror);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      B_L:     bus.btn_left   = v;
      B_R:     bus.btn_right  = v;
      B_U:     bus.btn_up     = v;
      B_D:     bus.btn_down   = v;
      default: bus.btn_attack = v;
    endcase
  endtask

  task automatic pulse(input int which);
    set_btn(which, 1'b1); idle(2); set_btn(which, 1'b0); idle(1);
  endtask

  task automatic do_tick();
    bus.tick = 1'b1; idle(1); bus.tick = 1'b0; idle(2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"},      bus.x, 24);
    chk({tag, "_y"},      bus.y, 32);
    chk({tag, "_in_air"}, bus.in_air, 0);
    chk({tag, "_move"},   bus.move_state, 0);
    chk({tag, "_char"},   bus.character_state, 0);
    chk({tag, "_mirror"}, bus.mirror, 0);
  endtask

  // ---------------- stimulus ----------------
  int jump_y[13] = '{26, 21, 17, 14, 12, 11, 11, 12, 14, 17, 21, 26, 32};

  initial begin
    bus.tick = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_up = 1'b0;
    bus.btn_down = 1'b0; bus.btn_attack = 1'b0; bus.opponent_x = 7'd60;
    idle(2);
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(1);

    repeat (3) do_tick();
    chk_reset_vals("idle3");

    // walk right toward opponent
    set_btn(B_R, 1'b1);
    repeat (5) do_tick();
    chk("walk_r_x", bus.x, 29);
    chk("walk_r_move", bus.move_state, 1);
    chk("walk_r_mirror", bus.mirror, 0);
    set_btn(B_R, 1'b0);

    // walk left away, into the left clamp
    set_btn(B_L, 1'b1);
    do_tick();
    chk("walk_l_x", bus.x, 28);
    chk("walk_l_move", bus.move_state, 2);
    repeat (20) do_tick();
    chk("walk_l_at_min", bus.x, 8);
    do_tick();
    chk("clamp_l_x", bus.x, 8);
    chk("clamp_l_move", bus.move_state, 2);
    set_btn(B_L, 1'b0);

    // facing: opponent on the left, then level with us
    bus.opponent_x = 7'd4;
    set_btn(B_R, 1'b1);
    do_tick();
    chk("face_l_x", bus.x, 9);
    chk("face_l_mirror", bus.mirror, 1);
    chk("face_l_move", bus.move_state, 2);
    set_btn(B_R, 1'b0);
    bus.opponent_x = 7'd9;
    do_tick();
    chk("face_eq_mirror_hold", bus.mirror, 1);
    chk("face_eq_move", bus.move_state, 0);
    bus.opponent_x = 7'd60;
    do_tick();
    chk("face_r_mirror", bus.mirror, 0);

    // jump arc, with an ignored mid-air up press
    pulse(B_U);
    for (int k = 0; k < 13; k++) begin
      if (k == 3) pulse(B_U);
      do_tick();
      chk("jump_y", bus.y, jump_y[k]);
      chk("jump_in_air", bus.in_air, (k < 12) ? 1 : 0);
    end
    do_tick();
    chk("after_land_y", bus.y, 32);

    // punch, second press during it dropped
    pulse(B_A);
    do_tick(); chk("punch_t1", bus.character_state, 1);
    pulse(B_A);
    do_tick(); chk("punch_t2", bus.character_state, 1);
    do_tick(); chk("punch_t3", bus.character_state, 0);
    do_tick(); chk("punch_t4_no_requeue", bus.character_state, 0);

    // L,D,R combo within window -> special for 4 ticks
    pulse(B_L); repeat (2) do_tick();
    pulse(B_D); repeat (2) do_tick();
    pulse(B_R); repeat (2) do_tick();
    pulse(B_A);
    for (int k = 0; k < 5; k++) begin
      do_tick();
      chk("special_t", bus.character_state, (k < 4) ? 2 : 0);
    end

    // same combo, window expired -> plain punch
    pulse(B_L); repeat (2) do_tick();
    pulse(B_D); repeat (2) do_tick();
    pulse(B_R); repeat (9) do_tick();
    pulse(B_A);
    do_tick(); chk("expired_combo_punch", bus.character_state, 1);
    repeat (2) do_tick();
    chk("expired_combo_done", bus.character_state, 0);

    // super sequence (also launches a jump through the U press)
    pulse(B_U); pulse(B_D); pulse(B_U); pulse(B_D);
    pulse(B_L); pulse(B_R); pulse(B_L); pulse(B_R);
    pulse(B_A);
    do_tick();
    chk("super_seq_char", bus.character_state, SUPER ? 3 : 1);
    chk("super_seq_air", bus.in_air, 1);
    repeat (14) do_tick();
    chk("super_seq_done_char", bus.character_state, 0);
    chk("super_seq_done_air", bus.in_air, 0);

    // jump and attack on the same tick, then async reset mid-air/mid-attack
    bus.opponent_x = 7'd4;
    set_btn(B_U, 1'b1); set_btn(B_A, 1'b1); idle(2);
    set_btn(B_U, 1'b0); set_btn(B_A, 1'b0); idle(1);
    do_tick();
    chk("simul_air", bus.in_air, 1);
    chk("simul_y", bus.y, 26);
    chk("simul_char", bus.character_state, 1);
    chk("simul_mirror", bus.mirror, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    idle(2);
    rst_n = 1'b1;
    bus.opponent_x = 7'd60;
    idle(1);
    do_tick();
    chk_reset_vals("post_rst");

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: stimulus did not complete, time %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
